pool1_exec: RTL and testbench

//  S2 subsampling stage, directly downstream of the C1 convolution stage.

---
 rtl/pool1_exec_pkg.sv | 18 +
 rtl/pool1_exec_pool_unit.sv | 50 +++++
 rtl/pool1_exec.sv | 113 +++++++++++
 tb/tb_pool1_exec.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pool1_exec_pkg.sv
// Shared constants and types for the S2 (2x2 / stride-2 signed max pooling) stage.
// These values are the defaults that pool1_exec and pool_unit take for their parameters.
package pool1_exec_pkg;

  localparam int DW_C    = 16;
  localparam int C1_SIZE = 28;
  localparam int S2_SIZE = C1_SIZE / 2;
  localparam int S2_AW   = 8;
  localparam int NCH     = 6;

  // Pixel position of the current beat, produced once by the counter logic and fanned out to every channel.
  typedef struct packed {
    logic beat;
    logic col_odd;
    logic row_odd;
  } beat_ctrl_t;

endpackage

// File: rtl/pool1_exec_pool_unit.sv
// One channel of S2 max pooling: horizontal pair register, half-width line buffer, vertical max.
// Build option POOL1_RELU_EN clamps negative pooled results to zero before they are registered.
module pool_unit
  import pool1_exec_pkg::*;
#(
  parameter int DW    = DW_C,
  parameter int IMG_W = C1_SIZE,
  parameter int HW    = $clog2(IMG_W) - 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  beat_ctrl_t    ctrl,
  input  logic [HW-1:0] half_col,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  logic [DW-1:0] hreg;
  logic [DW-1:0] hmax;
  logic [DW-1:0] res;
  logic [DW-1:0] lbuf [IMG_W/2];

  function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  assign hmax = smax(hreg, d);
  assign res  = smax(lbuf[half_col], hmax);

  // The line buffer and the pair register are not reset: after a reset the next frame overwrites them before it reads them.
  always_ff @(posedge clk) begin
    if (ctrl.beat && !ctrl.col_odd)
      hreg <= d;
    if (ctrl.beat && ctrl.col_odd && !ctrl.row_odd)
      lbuf[half_col] <= hmax;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (ctrl.beat && ctrl.col_odd && ctrl.row_odd) begin
`ifdef POOL1_RELU_EN
      q <= res[DW-1] ? '0 : res;
`else
      q <= res;
`endif
    end
  end

endmodule

// File: rtl/pool1_exec.sv
// S2 subsampling stage: raster pixel counters, pooled address/strobe generation, and six pool_unit channels.
// Build option POOL1_RELU_EN (see pool_unit) applies ReLU to the pooled results.
module pool1_exec
  import pool1_exec_pkg::*;
#(
  parameter int DW    = DW_C,
  parameter int IMG_W = C1_SIZE,
  parameter int IMG_H = C1_SIZE,
  parameter int AW    = S2_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_sync,
  input  logic          f2_wr_en,
  input  logic [DW-1:0] f2_1_wdata,
  input  logic [DW-1:0] f2_2_wdata,
  input  logic [DW-1:0] f2_3_wdata,
  input  logic [DW-1:0] f2_4_wdata,
  input  logic [DW-1:0] f2_5_wdata,
  input  logic [DW-1:0] f2_6_wdata,
  output logic          s2_wr_en,
  output logic [AW-1:0] s2_waddr,
  output logic [DW-1:0] s2_1_wdata,
  output logic [DW-1:0] s2_2_wdata,
  output logic [DW-1:0] s2_3_wdata,
  output logic [DW-1:0] s2_4_wdata,
  output logic [DW-1:0] s2_5_wdata,
  output logic [DW-1:0] s2_6_wdata,
  output logic          frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] ecol;
  logic [RW-1:0] erow;
  logic          emit;
  logic          last_pix;
  logic [AW-1:0] addr_next;
  beat_ctrl_t    ctrl;
  logic [DW-1:0] din  [NCH];
  logic [DW-1:0] dout [NCH];

  // frame_sync redefines the current beat as pixel (0,0), so datapath and address use the effective position.
  assign ecol     = frame_sync ? '0 : col;
  assign erow     = frame_sync ? '0 : row;
  assign last_pix = (ecol == CW'(IMG_W - 1)) && (erow == RW'(IMG_H - 1));
  assign emit     = f2_wr_en && ecol[0] && erow[0];
  assign addr_next = AW'(32'(erow >> 1) * 32'(IMG_W / 2) + 32'(ecol >> 1));

  assign ctrl.beat    = f2_wr_en;
  assign ctrl.col_odd = ecol[0];
  assign ctrl.row_odd = erow[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      s2_wr_en   <= 1'b0;
      frame_done <= 1'b0;
      s2_waddr   <= '0;
    end else begin
      s2_wr_en   <= emit;
      frame_done <= emit && last_pix;
      if (emit)
        s2_waddr <= addr_next;
      if (f2_wr_en) begin
        if (ecol == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= (erow == RW'(IMG_H - 1)) ? '0 : erow + RW'(1);
        end else begin
          col <= ecol + CW'(1);
          row <= erow;
        end
      end else if (frame_sync) begin
        col <= '0;
        row <= '0;
      end
    end
  end

  assign din[0] = f2_1_wdata;
  assign din[1] = f2_2_wdata;
  assign din[2] = f2_3_wdata;
  assign din[3] = f2_4_wdata;
  assign din[4] = f2_5_wdata;
  assign din[5] = f2_6_wdata;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    pool_unit #(
      .DW    (DW),
      .IMG_W (IMG_W),
      .HW    (CW - 1)
    ) u_pool (
      .clk      (clk),
      .rst_n    (rst_n),
      .ctrl     (ctrl),
      .half_col (ecol[CW-1:1]),
      .d        (din[g]),
      .q        (dout[g])
    );
  end

  assign s2_1_wdata = dout[0];
  assign s2_2_wdata = dout[1];
  assign s2_3_wdata = dout[2];
  assign s2_4_wdata = dout[3];
  assign s2_5_wdata = dout[4];
  assign s2_6_wdata = dout[5];

endmodule

// File: tb/tb_pool1_exec.sv
// Bench for pool1_exec: fixed 2x2 window vectors plus randomized frames checked against an image-array model.
// Define POOL1_RELU_EN for both bench and design to check the ReLU build.
module tb_pool1_exec;

  localparam int W     = 28;
  localparam int H     = 28;
  localparam int NPIX  = W * H;
  localparam int PW    = W / 2;
  localparam int NPOOL = (W / 2) * (H / 2);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_sync;
  logic        f2_wr_en;
  logic [15:0] din [6];
  logic        s2_wr_en;
  logic [7:0]  s2_waddr;
  logic [15:0] s2_1_wdata, s2_2_wdata, s2_3_wdata, s2_4_wdata, s2_5_wdata, s2_6_wdata;
  logic        frame_done;
  logic [15:0] dout [6];

  always #5 clk = ~clk;

  pool1_exec dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_sync (frame_sync),
    .f2_wr_en   (f2_wr_en),
    .f2_1_wdata (din[0]),
    .f2_2_wdata (din[1]),
    .f2_3_wdata (din[2]),
    .f2_4_wdata (din[3]),
    .f2_5_wdata (din[4]),
    .f2_6_wdata (din[5]),
    .s2_wr_en   (s2_wr_en),
    .s2_waddr   (s2_waddr),
    .s2_1_wdata (s2_1_wdata),
    .s2_2_wdata (s2_2_wdata),
    .s2_3_wdata (s2_3_wdata),
    .s2_4_wdata (s2_4_wdata),
    .s2_5_wdata (s2_5_wdata),
    .s2_6_wdata (s2_6_wdata),
    .frame_done (frame_done)
  );

  assign dout[0] = s2_1_wdata;
  assign dout[1] = s2_2_wdata;
  assign dout[2] = s2_3_wdata;
  assign dout[3] = s2_4_wdata;
  assign dout[4] = s2_5_wdata;
  assign dout[5] = s2_6_wdata;

  // Reference model: the whole current frame is kept per channel and each window is pooled from it directly.
  int          p;
  logic [15:0] img [6][NPIX];
  logic        e_wr, e_done;
  logic [7:0]  e_addr;
  logic [15:0] e_data [6];
  int          checks = 0;
  int          failures = 0;
  int          wr_cnt, done_cnt;
  bit          ramp_chk = 0;

  typedef struct {
    logic [15:0] w [4];
    logic [15:0] exp_plain;
    logic [15:0] exp_relu;
  } vec_t;
  vec_t vecs [7];

  function automatic logic [15:0] smax(input logic [15:0] a, input logic [15:0] b);
    return ($signed(a) >= $signed(b)) ? a : b;
  endfunction

  function automatic logic [15:0] relu(input logic [15:0] a);
`ifdef POOL1_RELU_EN
    return ($signed(a) < 0) ? 16'h0000 : a;
`else
    return a;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (time %0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic beat, input logic sync);
    int r, c, k;
    rst_n      = ~rst;
    f2_wr_en   = beat;
    frame_sync = sync;
    @(posedge clk);
    if (rst) begin
      p = 0; e_wr = 0; e_done = 0; e_addr = '0;
      for (int ch = 0; ch < 6; ch++) e_data[ch] = '0;
    end else begin
      e_wr = 0; e_done = 0;
      if (sync) p = 0;
      if (beat) begin
        r = p / W; c = p % W;
        for (int ch = 0; ch < 6; ch++) img[ch][p] = din[ch];
        if ((r % 2 == 1) && (c % 2 == 1)) begin
          e_wr   = 1;
          e_addr = 8'((r / 2) * PW + c / 2);
          e_done = (int'(e_addr) == NPOOL - 1);
          for (int ch = 0; ch < 6; ch++)
            e_data[ch] = relu(smax(smax(img[ch][p-W-1], img[ch][p-W]),
                                   smax(img[ch][p-1], img[ch][p])));
        end
        p = (p + 1) % NPIX;
      end
    end
    #1;
    check("s2_wr_en", 32'(s2_wr_en), 32'(e_wr));
    check("frame_done", 32'(frame_done), 32'(e_done));
    check("s2_waddr", 32'(s2_waddr), 32'(e_addr));
    for (int ch = 0; ch < 6; ch++) check($sformatf("s2_%0d_wdata", ch + 1), 32'(dout[ch]), 32'(e_data[ch]));
    if (s2_wr_en) begin
      wr_cnt++;
      if (frame_done) done_cnt++;
      if (ramp_chk) begin
        k = int'(s2_waddr);
        check("ramp_value", 32'(s2_1_wdata), 32'((2 * (k / 14) + 1) * 28 + 2 * (k % 14) + 1));
      end
    end
    @(negedge clk);
  endtask

  // mode 0: ch1 ramp, others random; mode 1: ch n constant 0x100*n; mode 2: all random
  function automatic logic [15:0] gen(input int mode, input int ch, input int pix);
    case (mode)
      0:       return (ch == 0) ? 16'(pix) : 16'($urandom);
      1:       return 16'(16'h0100 * (ch + 1));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic run_beats(input int mode, input int n, input int gap_pct, input int sync_at);
    int  k = 0;
    logic s;
    while (k < n) begin
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        for (int ch = 0; ch < 6; ch++) din[ch] = 16'($urandom);
        step(0, 0, 0);
      end else begin
        s = (k == sync_at);
        if (s) begin wr_cnt = 0; done_cnt = 0; end
        for (int ch = 0; ch < 6; ch++) din[ch] = gen(mode, ch, s ? 0 : p);
        step(0, 1, s);
        k++;
      end
    end
  endtask

  task automatic frame_totals(input string tag);
    check({tag, "_writes"}, 32'(wr_cnt), 32'(NPOOL));
    check({tag, "_frame_done"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{w: '{16'hFFFE, 16'h8000, 16'hFFFF, 16'hC000}, exp_plain: 16'hFFFF, exp_relu: 16'h0000};
    vecs[1] = '{w: '{16'h0001, 16'h0002, 16'h0003, 16'h0004}, exp_plain: 16'h0004, exp_relu: 16'h0004};
    vecs[2] = '{w: '{16'h7FFF, 16'h8000, 16'h0000, 16'h0001}, exp_plain: 16'h7FFF, exp_relu: 16'h7FFF};
    vecs[3] = '{w: '{16'h8000, 16'h8000, 16'h8000, 16'h8000}, exp_plain: 16'h8000, exp_relu: 16'h0000};
    vecs[4] = '{w: '{16'h0005, 16'h0005, 16'h0005, 16'h0005}, exp_plain: 16'h0005, exp_relu: 16'h0005};
    vecs[5] = '{w: '{16'h0000, 16'hFFFF, 16'h8001, 16'hFFF0}, exp_plain: 16'h0000, exp_relu: 16'h0000};
    vecs[6] = '{w: '{16'hFF00, 16'h0010, 16'h1234, 16'h0FFF}, exp_plain: 16'h1234, exp_relu: 16'h1234};

    for (int ch = 0; ch < 6; ch++) din[ch] = 16'hA5A5;
    wr_cnt = 0; done_cnt = 0;
    step(1, 0, 0);
    step(1, 1, 0);
    check("reset_wr_en", 32'(s2_wr_en), 32'd0);
    check("reset_addr", 32'(s2_waddr), 32'd0);
    check("reset_data", 32'(s2_1_wdata), 32'd0);

    // Fixed windows at pixels (0,0),(0,1),(1,0),(1,1); frame_sync on the first beat restarts each one.
    for (int v = 0; v < 7; v++) begin
      for (int pi = 0; pi < W + 2; pi++) begin
        for (int ch = 0; ch < 6; ch++) din[ch] = 16'($urandom);
        if (pi == 0)     din[0] = vecs[v].w[0];
        if (pi == 1)     din[0] = vecs[v].w[1];
        if (pi == W)     din[0] = vecs[v].w[2];
        if (pi == W + 1) din[0] = vecs[v].w[3];
        step(0, 1, pi == 0);
      end
`ifdef POOL1_RELU_EN
      check($sformatf("vec%0d_data", v), 32'(s2_1_wdata), 32'(vecs[v].exp_relu));
`else
      check($sformatf("vec%0d_data", v), 32'(s2_1_wdata), 32'(vecs[v].exp_plain));
`endif
      check($sformatf("vec%0d_strobe", v), {s2_wr_en, 23'd0, s2_waddr}, {1'b1, 31'd0});
    end

    ramp_chk = 1;
    run_beats(0, NPIX, 0, 0);
    frame_totals("ramp");
    run_beats(0, NPIX, 30, 0);
    frame_totals("gaps");
    ramp_chk = 0;

    run_beats(1, NPIX, 10, 0);
    frame_totals("const");

    run_beats(2, 300, 0, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    ramp_chk = 1;
    run_beats(0, NPIX, 0, 0);
    frame_totals("after_reset");
    ramp_chk = 0;

    run_beats(2, 100 + NPIX, 0, 100);
    frame_totals("sync_mid");

    run_beats(2, NPIX, 20, 0);
    frame_totals("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
